// File: rtl/mem_bus_arbiter.sv
// N-master arbiter onto one byte-wide RAM/IO bus with burst locking and a
// 1-cycle read return steered by the registered source of the issuing access.
module mem_bus_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int ARB_MODE       = 0
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [N_MASTERS-1:0]            m_req,
    input  logic [N_MASTERS-1:0]            m_lock,
    input  logic [N_MASTERS-1:0]            m_wr,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [N_MASTERS*8-1:0]          m_wdata,
    output logic [N_MASTERS-1:0]            m_gnt,
    output logic [N_MASTERS-1:0]            m_rvalid,
    output logic [7:0]                      m_rdata,
    output logic                            ram_en,
    output logic                            ram_r_nw,
    output logic [RAM_ADDR_WIDTH-1:0]       ram_a,
    output logic [7:0]                      ram_din,
    input  logic [7:0]                      ram_dout,
    output logic                            io_en,
    output logic [2:0]                      io_sel,
    output logic                            io_wr,
    output logic [7:0]                      io_din,
    input  logic [7:0]                      io_dout
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    idx_t                  rr_ptr;
    idx_t                  lock_owner;
    idx_t                  rd_owner;
    idx_t                  fp_idx;
    idx_t                  rr_idx;
    idx_t                  gnt_idx;
    idx_t                  rr_next;
    logic                  rr_found;
    int                    cand;
    logic                  lock_valid;
    logic                  lock_hit;
    logic                  gnt_any;
    logic                  gnt_wr;
    logic                  gnt_lock;
    logic [7:0]            gnt_wdata;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic                  io_hit;
    logic                  rd_pending;
    logic                  rd_io;
    logic                  unused_addr_bits;

    // A held lock only wins while its owner keeps requesting.
    assign lock_hit = lock_valid & m_req[lock_owner];

    // NOTE: each always_comb output is given a default before any branch so no
    // path can leave it holding its old value, which would infer a latch.
    always_comb begin
        fp_idx = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (m_req[i]) fp_idx = idx_t'(i);
        end
    end

    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = 0;
        for (int k = 0; k < N_MASTERS; k++) begin
            cand = (int'(rr_ptr) + k) % N_MASTERS;
            if (!rr_found && m_req[cand]) begin
                rr_idx   = idx_t'(cand);
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        if (lock_hit)           gnt_idx = lock_owner;
        else if (ARB_MODE == 1) gnt_idx = rr_idx;
        else                    gnt_idx = fp_idx;
    end

    // Reset gates the grant so the bus stays quiet while rst_in is low.
    assign gnt_any   = rst_in & (|m_req);
    assign m_gnt     = gnt_any ? (N_MASTERS'(1) << gnt_idx) : '0;

    assign gnt_addr  = m_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign gnt_wdata = m_wdata[int'(gnt_idx)*8 +: 8];
    assign gnt_wr    = m_wr[gnt_idx];
    assign gnt_lock  = m_lock[gnt_idx];
    assign rr_next   = idx_t'((int'(gnt_idx) + 1) % N_MASTERS);

    assign io_hit    = (gnt_addr[RAM_ADDR_WIDTH -: 2] == 2'b11);
    assign ram_en    = gnt_any & ~io_hit;
    assign io_en     = gnt_any & io_hit;
    assign ram_r_nw  = ~(gnt_any & gnt_wr);
    assign io_wr     = io_en & gnt_wr;
    assign ram_a     = gnt_addr[RAM_ADDR_WIDTH-1:0];
    assign io_sel    = gnt_addr[2:0];
    assign ram_din   = gnt_wdata;
    assign io_din    = gnt_wdata;

    assign unused_addr_bits = ^gnt_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH+1];

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_owner <= '0;
            rd_pending <= 1'b0;
            rd_owner   <= '0;
            rd_io      <= 1'b0;
        end else begin
            lock_valid <= gnt_any & gnt_lock;
            rd_pending <= gnt_any & ~gnt_wr;
            if (gnt_any) begin
                lock_owner <= gnt_idx;
                rd_owner   <= gnt_idx;
                rd_io      <= io_hit;
            end
            if (gnt_any && !lock_hit) rr_ptr <= rr_next;
        end
    end

    // Return data follows the source captured at issue, not the current decode.
    assign m_rvalid = rd_pending ? (N_MASTERS'(1) << rd_owner) : '0;
    assign m_rdata  = rd_io ? io_dout : ram_dout;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: a fixed-priority 2-master instance and a round-robin
// 3-master instance, checked against hand-computed values.
module tb_mem_bus_arbiter;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [7:0] ram_dout = 8'hA5;
    logic [7:0] io_dout  = 8'h3C;

    logic [1:0]  fp_req, fp_lock, fp_wr, fp_gnt, fp_rvalid;
    logic [63:0] fp_addr;
    logic [15:0] fp_wdata;
    logic [7:0]  fp_rdata, fp_ram_din, fp_io_din;
    logic        fp_ram_en, fp_ram_r_nw, fp_io_en, fp_io_wr;
    logic [16:0] fp_ram_a;
    logic [2:0]  fp_io_sel;

    logic [2:0]  rr_req, rr_lock, rr_wr, rr_gnt, rr_rvalid;
    logic [95:0] rr_addr;
    logic [23:0] rr_wdata;
    logic [7:0]  rr_rdata, rr_ram_din, rr_io_din;
    logic        rr_ram_en, rr_ram_r_nw, rr_io_en, rr_io_wr;
    logic [16:0] rr_ram_a;
    logic [2:0]  rr_io_sel;

    mem_bus_arbiter #(.N_MASTERS(2), .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(17), .ARB_MODE(0)) dut_fp (
        .clk_in(clk_in), .rst_in(rst_in),
        .m_req(fp_req), .m_lock(fp_lock), .m_wr(fp_wr), .m_addr(fp_addr), .m_wdata(fp_wdata),
        .m_gnt(fp_gnt), .m_rvalid(fp_rvalid), .m_rdata(fp_rdata),
        .ram_en(fp_ram_en), .ram_r_nw(fp_ram_r_nw), .ram_a(fp_ram_a), .ram_din(fp_ram_din),
        .ram_dout(ram_dout),
        .io_en(fp_io_en), .io_sel(fp_io_sel), .io_wr(fp_io_wr), .io_din(fp_io_din),
        .io_dout(io_dout)
    );

    mem_bus_arbiter #(.N_MASTERS(3), .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(17), .ARB_MODE(1)) dut_rr (
        .clk_in(clk_in), .rst_in(rst_in),
        .m_req(rr_req), .m_lock(rr_lock), .m_wr(rr_wr), .m_addr(rr_addr), .m_wdata(rr_wdata),
        .m_gnt(rr_gnt), .m_rvalid(rr_rvalid), .m_rdata(rr_rdata),
        .ram_en(rr_ram_en), .ram_r_nw(rr_ram_r_nw), .ram_a(rr_ram_a), .ram_din(rr_ram_din),
        .ram_dout(ram_dout),
        .io_en(rr_io_en), .io_sel(rr_io_sel), .io_wr(rr_io_wr), .io_din(rr_io_din),
        .io_dout(io_dout)
    );

    int n_eval = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fp_drive(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] wr,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [7:0] d0, input logic [7:0] d1);
        fp_req   = req;
        fp_lock  = lock;
        fp_wr    = wr;
        fp_addr  = {a1, a0};
        fp_wdata = {d1, d0};
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 time units later.
    task automatic step();
        @(negedge clk_in);
    endtask

    initial begin
        rr_wr    = 3'b000;
        rr_addr  = '0;
        rr_wdata = '0;
        rr_req   = 3'b111;
        rr_lock  = 3'b000;
        fp_drive(2'b11, 2'b00, 2'b00, 32'h10, 32'h20, 8'h00, 8'h00);

        // Reset with every master requesting.
        step(); step(); #2;
        check("rst_fp_gnt",    32'(fp_gnt),      32'h0);
        check("rst_ram_en",    32'(fp_ram_en),   32'h0);
        check("rst_io_en",     32'(fp_io_en),    32'h0);
        check("rst_io_wr",     32'(fp_io_wr),    32'h0);
        check("rst_ram_r_nw",  32'(fp_ram_r_nw), 32'h1);
        check("rst_fp_rvalid", 32'(fp_rvalid),   32'h0);
        check("rst_rr_gnt",    32'(rr_gnt),      32'h0);
        check("rst_rr_rvalid", 32'(rr_rvalid),   32'h0);

        // Fixed priority starves master 1; round-robin rotates 001,010,100,001.
        step(); rst_in = 1'b1; #2;
        check("fp_gnt_c1",  32'(fp_gnt),      32'h1);
        check("fp_ram_en",  32'(fp_ram_en),   32'h1);
        check("fp_ram_a",   32'(fp_ram_a),    32'h10);
        check("fp_rd_rnw",  32'(fp_ram_r_nw), 32'h1);
        check("rr_gnt_c1",  32'(rr_gnt),      32'h1);
        step(); #2;
        check("fp_gnt_c2",  32'(fp_gnt),      32'h1);
        check("fp_rv_c2",   32'(fp_rvalid),   32'h1);
        check("fp_rd_c2",   32'(fp_rdata),    32'hA5);
        check("rr_gnt_c2",  32'(rr_gnt),      32'h2);
        step(); #2;
        check("fp_gnt_c3",  32'(fp_gnt),      32'h1);
        check("rr_gnt_c3",  32'(rr_gnt),      32'h4);
        step(); #2;
        check("rr_gnt_c4",  32'(rr_gnt),      32'h1);
        check("rr_rv_c4",   32'(rr_rvalid),   32'h4);

        // Idle: bus quiet, last reads still return.
        step(); fp_drive(2'b00, 2'b00, 2'b00, 32'h10, 32'h20, 8'h00, 8'h00); rr_req = 3'b000; #2;
        check("idle_gnt",    32'(fp_gnt),    32'h0);
        check("idle_ram_en", 32'(fp_ram_en), 32'h0);
        check("idle_io_en",  32'(fp_io_en),  32'h0);
        check("idle_fp_rv",  32'(fp_rvalid), 32'h1);
        check("idle_rr_gnt", 32'(rr_gnt),    32'h0);
        check("idle_rr_rv",  32'(rr_rvalid), 32'h1);
        step(); #2;
        check("idle2_fp_rv", 32'(fp_rvalid), 32'h0);

        // IO read by master 1, then RAM read by master 0 back-to-back.
        step(); fp_drive(2'b10, 2'b00, 2'b00, 32'h10, 32'h00030004, 8'h00, 8'h00); #2;
        check("io_gnt",    32'(fp_gnt),    32'h2);
        check("io_en",     32'(fp_io_en),  32'h1);
        check("io_ram_en", 32'(fp_ram_en), 32'h0);
        check("io_sel",    32'(fp_io_sel), 32'h4);
        check("io_rd_wr",  32'(fp_io_wr),  32'h0);
        step(); fp_drive(2'b01, 2'b00, 2'b00, 32'h10, 32'h00030004, 8'h00, 8'h00); #2;
        check("b2b_gnt",    32'(fp_gnt),    32'h1);
        check("b2b_ram_en", 32'(fp_ram_en), 32'h1);
        check("b2b_io_en",  32'(fp_io_en),  32'h0);
        check("b2b_rv",     32'(fp_rvalid), 32'h2);
        check("b2b_rdata",  32'(fp_rdata),  32'h3C);

        // IO write by master 1 while master 0's RAM read returns.
        step(); fp_drive(2'b10, 2'b00, 2'b10, 32'h10, 32'h00030007, 8'h00, 8'h5A); #2;
        check("iow_rv",     32'(fp_rvalid),   32'h1);
        check("iow_rdata",  32'(fp_rdata),    32'hA5);
        check("iow_io_wr",  32'(fp_io_wr),    32'h1);
        check("iow_sel",    32'(fp_io_sel),   32'h7);
        check("iow_din",    32'(fp_io_din),   32'h5A);
        check("iow_rnw",    32'(fp_ram_r_nw), 32'h0);
        step(); fp_drive(2'b00, 2'b00, 2'b00, 32'h10, 32'h20, 8'h00, 8'h00); #2;
        check("iow_no_rv",  32'(fp_rvalid),   32'h0);

        // Locked 4-byte write burst by master 0 with master 1 waiting.
        for (int i = 0; i < 4; i++) begin
            step();
            fp_drive(2'b11, {1'b0, (i < 3)}, 2'b01, 32'h100 + 32'(i), 32'h20, 8'hD0 + 8'(i), 8'h00);
            #2;
            check("burst_gnt", 32'(fp_gnt),      32'h1);
            check("burst_a",   32'(fp_ram_a),    32'h100 + 32'(i));
            check("burst_din", 32'(fp_ram_din),  32'hD0 + 32'(i));
            check("burst_rnw", 32'(fp_ram_r_nw), 32'h0);
            if (i == 1) check("burst_rv", 32'(fp_rvalid), 32'h0);
        end
        step(); fp_drive(2'b10, 2'b00, 2'b01, 32'h103, 32'h20, 8'h00, 8'h00); #2;
        check("post_burst_gnt", 32'(fp_gnt),      32'h2);
        check("post_burst_a",   32'(fp_ram_a),    32'h20);
        check("post_burst_rnw", 32'(fp_ram_r_nw), 32'h1);

        // Round-robin lock: rr_ptr is 1 here.
        step(); rr_req = 3'b111; rr_lock = 3'b010; #2;
        check("rrl_take",   32'(rr_gnt), 32'h2);
        step(); #2;
        check("rrl_hold",   32'(rr_gnt), 32'h2);
        step(); rr_req = 3'b101; #2;
        check("rrl_drop",   32'(rr_gnt), 32'h4);
        step(); rr_req = 3'b111; rr_lock = 3'b000; #2;
        check("rrl_cleared", 32'(rr_gnt), 32'h1);
        step(); rr_lock = 3'b010; #2;
        check("rrl_take2",  32'(rr_gnt), 32'h2);
        step(); rr_lock = 3'b000; #2;
        check("rrl_last",   32'(rr_gnt), 32'h2);
        step(); #2;
        check("rrl_free",   32'(rr_gnt), 32'h4);

        // Reset the cycle after a read grant, with a lock held and rr_ptr nonzero.
        step(); rr_req = 3'b010; rr_lock = 3'b010;
        fp_drive(2'b01, 2'b00, 2'b00, 32'h40, 32'h20, 8'h00, 8'h00); #2;
        check("pre_rst_fp_gnt", 32'(fp_gnt), 32'h1);
        check("pre_rst_rr_gnt", 32'(rr_gnt), 32'h2);
        step(); rst_in = 1'b0; #2;
        check("mid_rst_rv",  32'(fp_rvalid), 32'h0);
        check("mid_rst_gnt", 32'(fp_gnt),    32'h0);
        check("mid_rst_rr",  32'(rr_gnt),    32'h0);
        step(); rst_in = 1'b1; rr_req = 3'b111; rr_lock = 3'b000;
        fp_drive(2'b00, 2'b00, 2'b00, 32'h40, 32'h20, 8'h00, 8'h00); #2;
        check("rel_rr_ptr0", 32'(rr_gnt),    32'h1);
        check("rel_fp_rv",   32'(fp_rvalid), 32'h0);
        step(); #2;
        check("rel2_fp_rv",  32'(fp_rvalid), 32'h0);
        check("rel2_rr_rv",  32'(rr_rvalid), 32'h1);
        check("rel2_rr_gnt", 32'(rr_gnt),    32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
